// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module      : instr_fetch_pkg
// Description : ISA opcode encoding, fetch FSM states and operand decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  localparam int         c_ISA_WIDTH = 8;

  localparam logic [7:0] c_OP_LDACI  = 8'd0;
  localparam logic [7:0] c_OP_STACI  = 8'd13;
  localparam logic [7:0] c_OP_CLRAC  = 8'd24;
  localparam logic [7:0] c_OP_INAC   = 8'd26;
  localparam logic [7:0] c_OP_JPNZ   = 8'd27;
  localparam logic [7:0] c_OP_ENDOP  = 8'd28;
  localparam logic [7:0] c_OP_NOP    = 8'd34;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OP_ADDR  = 3'd1,
    S_OP_DATA  = 3'd2,
    S_ARG_ADDR = 3'd3,
    S_ARG_DATA = 3'd4,
    S_ISSUE    = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  // Only these opcodes are followed by an operand byte in program memory.
  function automatic logic op_has_operand(input logic [7:0] op);
    return (op == c_OP_LDACI) || (op == c_OP_STACI) || (op == c_OP_JPNZ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : PC-driven byte fetch, 1/2-byte instruction assembly and
//               valid/ready issue to the control unit; jumps and ENDOP halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  has_operand,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal
);

  state_t                r_state,   w_state_nx;
  logic [ADDR_WIDTH-1:0] r_pc,      w_pc_nx;
  logic [DATA_WIDTH-1:0] r_opcode,  w_opcode_nx;
  logic [DATA_WIDTH-1:0] r_operand, w_operand_nx;
  logic                  r_valid,   w_valid_nx;
  logic                  r_has_op,  w_has_op_nx;
  logic                  r_halted,  w_halted_nx;
  logic                  r_illegal, w_illegal_nx;
  logic [c_ISA_WIDTH-1:0] w_isa_byte;

  assign w_isa_byte = r_instr[c_ISA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_operand <= '0;
      r_valid   <= 1'b0;
      r_has_op  <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_opcode  <= w_opcode_nx;
      r_operand <= w_operand_nx;
      r_valid   <= w_valid_nx;
      r_has_op  <= w_has_op_nx;
      r_halted  <= w_halted_nx;
      r_illegal <= w_illegal_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_opcode_nx  = r_opcode;
    w_operand_nx = r_operand;
    w_valid_nx   = r_valid;
    w_has_op_nx  = r_has_op;
    w_halted_nx  = r_halted;
    w_illegal_nx = r_illegal;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_pc_nx      = '0;
          w_halted_nx  = 1'b0;
          w_illegal_nx = 1'b0;
          w_state_nx   = S_OP_ADDR;
        end
      end
      S_OP_ADDR: w_state_nx = S_OP_DATA;
      // r_instr now holds the byte addressed by PC during OP_ADDR.
      S_OP_DATA: begin
        w_opcode_nx = r_instr;
        w_pc_nx     = r_pc + ADDR_WIDTH'(1);
        if (w_isa_byte > c_OP_NOP) begin
          w_illegal_nx = 1'b1;
        end
        if (op_has_operand(w_isa_byte)) begin
          w_has_op_nx = 1'b1;
          w_state_nx  = S_ARG_ADDR;
        end else begin
          w_has_op_nx  = 1'b0;
          w_operand_nx = '0;
          w_valid_nx   = 1'b1;
          w_state_nx   = S_ISSUE;
        end
      end
      S_ARG_ADDR: w_state_nx = S_ARG_DATA;
      S_ARG_DATA: begin
        w_operand_nx = r_instr;
        w_pc_nx      = r_pc + ADDR_WIDTH'(1);
        w_valid_nx   = 1'b1;
        w_state_nx   = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) begin
          w_valid_nx = 1'b0;
          if (jump_en) begin
            w_pc_nx = jump_addr;
          end
          if (r_opcode[c_ISA_WIDTH-1:0] == c_OP_ENDOP) begin
            w_halted_nx = 1'b1;
            w_state_nx  = S_HALT;
          end else begin
            w_state_nx  = S_OP_ADDR;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign r_addr      = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign instr_valid = r_valid;
  assign has_operand = r_has_op;
  assign halted      = r_halted;
  assign illegal     = r_illegal;
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Randomized self-checking bench for instr_fetch against a
//               program-walking reference model with a registered memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] r_addr;
  logic [7:0] r_instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       has_operand;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
  logic       illegal;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;

  instr_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .r_addr      (r_addr),
    .r_instr     (r_instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .has_operand (has_operand),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-read program memory, same behaviour as instr_mem.
  always @(posedge clk) r_instr <= mem[r_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_r_addr", r_addr, 0);
    check("rst_pc", pc, 0);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_has_operand", has_operand, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Reference: what the instruction at address a looks like and where the
  // next fetch would start without a jump.
  task automatic predict(input logic [7:0] a, output logic [7:0] op, output logic [7:0] opr,
                         output logic has, output logic [7:0] nxt, output int lat);
    logic [7:0] a1;
    a1  = a + 8'd1;
    op  = mem[a];
    has = (op == 8'd0) || (op == 8'd13) || (op == 8'd27);
    if (has) begin
      opr = mem[a1];
      nxt = a1 + 8'd1;
      lat = 5;
    end else begin
      opr = 8'd0;
      nxt = a1;
      lat = 3;
    end
  endtask

  // jmode: 0 never jump on accept, 1 random jumps, 2 take every JPNZ,
  // 3 take only the first JPNZ, 4 jump to jtgt on the first accept only.
  task automatic run_prog(input int max_issues, input int ready_pct, input int jmode,
                          input logic [7:0] jtgt);
    logic [7:0] m_pc, f_pc, e_op, e_opr, nxt_pc;
    logic       e_has, m_ill, take;
    bit         seen, addr_chk, first, done;
    int         lat, exp_lat, issues, jumps;
    @(negedge clk);
    start = 1'b1; instr_ready = 1'b0; jump_en = 1'b0;
    m_pc = 8'd0; m_ill = 1'b0; issues = 0; jumps = 0; done = 0;
    predict(m_pc, e_op, e_opr, e_has, nxt_pc, exp_lat);
    m_ill = m_ill | (e_op > 8'd34);
    f_pc = m_pc; lat = 0; seen = 0; addr_chk = 1; first = 1;
    while (!done) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (first) begin
        check("start_halted", halted, 0);
        check("start_illegal", illegal, 0);
        first = 0;
      end
      if (addr_chk) begin
        check("r_addr", r_addr, f_pc);
        check("busy", busy, 1);
        addr_chk = 0;
      end
      if (instr_valid) begin
        if (!seen) begin
          check("latency", lat, exp_lat);
          seen = 1;
        end
        check("opcode", opcode, e_op);
        check("operand", operand, e_opr);
        check("has_operand", has_operand, e_has);
        check("pc_issue", pc, nxt_pc);
        check("illegal", illegal, m_ill);
        instr_ready = ($urandom_range(99) < ready_pct);
        jump_addr = e_opr;
        case (jmode)
          1: begin
            take = ($urandom_range(3) == 0);
            jump_addr = 8'($urandom_range(255));
          end
          2: take = (e_op == 8'd27);
          3: take = (e_op == 8'd27) && (jumps == 0);
          4: begin
            take = (issues == 0);
            jump_addr = jtgt;
          end
          default: take = 1'b0;
        endcase
        jump_en = take;
        if (instr_ready) begin
          issues++;
          if (take) jumps++;
          m_pc = take ? jump_addr : nxt_pc;
          if (e_op == 8'd28) begin
            @(negedge clk);
            check("halted", halted, 1);
            check("halt_busy", busy, 0);
            check("halt_valid", instr_valid, 0);
            check("halt_pc", pc, m_pc);
            check("halt_illegal", illegal, m_ill);
            done = 1;
          end else if (issues >= max_issues) begin
            done = 1;
          end else begin
            predict(m_pc, e_op, e_opr, e_has, nxt_pc, exp_lat);
            m_ill = m_ill | (e_op > 8'd34);
            f_pc = m_pc; lat = 0; seen = 0; addr_chk = 1;
          end
        end
      end else begin
        if (lat > exp_lat + 4) begin
          check("valid_timeout", 0, 1);
          done = 1;
        end
        // Handshake noise while nothing is presented must have no effect.
        instr_ready = 1'($urandom_range(1));
        jump_en     = 1'($urandom_range(1));
        jump_addr   = 8'($urandom_range(255));
      end
    end
    instr_ready = 1'b0;
    jump_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 8'd0;
    fill_mem(8'd28);
    #12 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Three one-byte instructions ending in ENDOP; pc finishes at 3.
    mem[0] = 8'd24; mem[1] = 8'd26; mem[2] = 8'd28;
    run_prog(20, 100, 0, 8'd0);

    // Two-byte instructions, then the same program with back-pressure.
    fill_mem(8'd28);
    mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd13; mem[3] = 8'd1; mem[4] = 8'd28;
    run_prog(20, 100, 0, 8'd0);
    run_prog(20, 25, 0, 8'd0);

    // JPNZ at 56: taken lands on 27, not taken continues at 58.
    fill_mem(8'd28);
    mem[0] = 8'd27; mem[1] = 8'd56; mem[56] = 8'd27; mem[57] = 8'd27; mem[58] = 8'd28;
    run_prog(20, 100, 2, 8'd0);
    run_prog(20, 60, 3, 8'd0);

    // Illegal byte at address 5 is issued as one-byte and sets the flag.
    fill_mem(8'd28);
    for (int i = 0; i < 5; i++) mem[i] = 8'd34;
    mem[5] = 8'hFF; mem[6] = 8'd28;
    run_prog(20, 100, 0, 8'd0);

    // LDACI at 255 takes its operand from address 0 after the wrap.
    fill_mem(8'd28);
    mem[0] = 8'd24; mem[255] = 8'd0; mem[1] = 8'd28;
    run_prog(20, 100, 4, 8'd255);

    // Reset in ARG_DATA drops the instruction; start resumes at 0.
    fill_mem(8'd28);
    mem[0] = 8'd13; mem[1] = 8'd1; mem[2] = 8'd28;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_opcode", opcode, 13);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_restart_busy", busy, 0);
    run_prog(20, 100, 0, 8'd0);

    // Random programs with random ready and random jumps.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(99) < 8) mem[i] = 8'($urandom_range(255, 35));
        else                        mem[i] = 8'($urandom_range(34));
      end
      run_prog(25, 70, 1, 8'd0);
      pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
